ex_muldiv: RTL

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, sitting beside the combinational ALU in the EX stage. It executes MULT/MULTU/DIV/DIVU iteratively (one bit per cycle) and holds the pipeline via `stall_req` while busy. It also serves MFHI/MFLO reads and MTHI/MTLO writes. This generalises the EX datapath from single-cycle ALU ops to stateful, stalling ops of configurable width.

---
 rtl/ex_muldiv_pkg.sv | 40 ++++
 rtl/ex_muldiv.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op codes, FSM states
// and the per-operation context latched on accept.
package ex_muldiv_pkg;

    localparam int unsigned MD_OP_BUS = 4;

    localparam logic [MD_OP_BUS-1:0] MD_OP_NONE  = 4'd0;
    localparam logic [MD_OP_BUS-1:0] MD_OP_MULT  = 4'd1;
    localparam logic [MD_OP_BUS-1:0] MD_OP_MULTU = 4'd2;
    localparam logic [MD_OP_BUS-1:0] MD_OP_DIV   = 4'd3;
    localparam logic [MD_OP_BUS-1:0] MD_OP_DIVU  = 4'd4;
    localparam logic [MD_OP_BUS-1:0] MD_OP_MFHI  = 4'd5;
    localparam logic [MD_OP_BUS-1:0] MD_OP_MFLO  = 4'd6;
    localparam logic [MD_OP_BUS-1:0] MD_OP_MTHI  = 4'd7;
    localparam logic [MD_OP_BUS-1:0] MD_OP_MTLO  = 4'd8;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // Sign/kind information captured on accept; operands are held as magnitudes.
    typedef struct packed {
        logic is_div;
        logic neg_res;
        logic neg_rem;
        logic div_zero;
    } md_ctx_t;

    function automatic logic md_is_arith(input logic [MD_OP_BUS-1:0] op);
        return (op == MD_OP_MULT) || (op == MD_OP_MULTU) ||
               (op == MD_OP_DIV)  || (op == MD_OP_DIVU);
    endfunction

    function automatic logic md_is_signed(input logic [MD_OP_BUS-1:0] op);
        return (op == MD_OP_MULT) || (op == MD_OP_DIV);
    endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative (radix-2) multiply/divide unit with architectural HI/LO registers.
// Stalls the pipeline from the accept cycle until the result is committed.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  op_valid,
    input  logic [MD_OP_BUS-1:0]  op,
    input  logic [DATA_WIDTH-1:0] operand_1,
    input  logic [DATA_WIDTH-1:0] operand_2,
    input  logic                  flush,
    output logic                  stall_req,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] hi_out,
    output logic [DATA_WIDTH-1:0] lo_out,
    output logic [DATA_WIDTH-1:0] mf_result
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned AW = 2 * DATA_WIDTH;

    md_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [AW-1:0]        acc_q;
    logic [W-1:0]         mcand_q;
    logic [W-1:0]         dividend_q;
    md_ctx_t              ctx_q;
    logic [W-1:0]         hi_q, lo_q;

    logic                 accept_c;
    logic                 mt_c;
    logic                 last_step_c;
    logic                 a_neg, b_neg;
    logic [W-1:0]         a_mag, b_mag;
    logic [AW-1:0]        acc_step;
    logic [W:0]           mul_sum;
    logic [W:0]           div_shift;
    logic [W:0]           div_diff;
    logic [AW-1:0]        prod_fix;
    logic [W-1:0]         res_hi, res_lo;

    // Issue decode: flush outranks both accept and MTHI/MTLO.
    assign accept_c    = (state_q == MD_IDLE) && op_valid && md_is_arith(op) && !flush;
    assign mt_c        = (state_q == MD_IDLE) && op_valid && !flush &&
                         ((op == MD_OP_MTHI) || (op == MD_OP_MTLO));
    assign last_step_c = (state_q == MD_BUSY) && (cnt_q == CNT_WIDTH'(W - 1));

    assign stall_req = accept_c || (state_q == MD_BUSY);
    assign busy      = (state_q == MD_BUSY);
    assign hi_out    = hi_q;
    assign lo_out    = lo_q;

    // Operand magnitudes; unsigned ops never flag a sign.
    always_comb begin
        a_neg = md_is_signed(op) && operand_1[W-1];
        b_neg = md_is_signed(op) && operand_2[W-1];
        a_mag = a_neg ? -operand_1 : operand_1;
        b_mag = b_neg ? -operand_2 : operand_2;
    end

    // One radix-2 step: shift-add multiply or restoring divide on {rem, quo}.
    always_comb begin
        acc_step  = acc_q;
        mul_sum   = '0;
        div_shift = '0;
        div_diff  = '0;
        if (ctx_q.is_div) begin
            div_shift = {acc_q[AW-1:W], acc_q[W-1]};
            div_diff  = div_shift - {1'b0, mcand_q};
            if (!div_diff[W]) begin
                acc_step = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
            end else begin
                acc_step = {div_shift[W-1:0], acc_q[W-2:0], 1'b0};
            end
        end else begin
            mul_sum  = {1'b0, acc_q[AW-1:W]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
            acc_step = {mul_sum, acc_q[W-1:1]};
        end
    end

    // Sign fixup of the final step, applied on the commit edge.
    always_comb begin
        prod_fix = ctx_q.neg_res ? -acc_step : acc_step;
        res_hi   = prod_fix[AW-1:W];
        res_lo   = prod_fix[W-1:0];
        if (ctx_q.is_div) begin
            if (ctx_q.div_zero) begin
                res_hi = dividend_q;
                res_lo = '1;
            end else begin
                res_hi = ctx_q.neg_rem ? -acc_step[AW-1:W] : acc_step[AW-1:W];
                res_lo = ctx_q.neg_res ? -acc_step[W-1:0]  : acc_step[W-1:0];
            end
        end
    end

    always_comb begin
        mf_result = '0;
        if (op == MD_OP_MFHI) begin
            mf_result = hi_q;
        end else if (op == MD_OP_MFLO) begin
            mf_result = lo_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MD_IDLE: begin
                if (accept_c) begin
                    state_d = MD_BUSY;
                end
            end
            MD_BUSY: begin
                if (flush) begin
                    state_d = MD_IDLE;
                end else if (last_step_c) begin
                    state_d = MD_DONE;
                end
            end
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, and HI/LO commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            dividend_q <= '0;
            ctx_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else if (accept_c) begin
            cnt_q          <= '0;
            dividend_q     <= operand_1;
            ctx_q.is_div   <= (op == MD_OP_DIV) || (op == MD_OP_DIVU);
            ctx_q.neg_res  <= a_neg ^ b_neg;
            ctx_q.neg_rem  <= a_neg;
            ctx_q.div_zero <= ((op == MD_OP_DIV) || (op == MD_OP_DIVU)) && (operand_2 == '0);
            if ((op == MD_OP_DIV) || (op == MD_OP_DIVU)) begin
                acc_q   <= {W'(0), a_mag};
                mcand_q <= b_mag;
            end else begin
                acc_q   <= {W'(0), b_mag};
                mcand_q <= a_mag;
            end
        end else if ((state_q == MD_BUSY) && !flush) begin
            acc_q <= acc_step;
            cnt_q <= cnt_q + CNT_WIDTH'(1);
            if (last_step_c) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
        end else if (mt_c) begin
            if (op == MD_OP_MTHI) begin
                hi_q <= operand_1;
            end else begin
                lo_q <= operand_1;
            end
        end
    end

endmodule
